// File: rtl/cdb_arbiter.sv
// CDB completion arbiter: per-FU result FIFOs drained onto WAYS common-data-bus
// lanes in round-robin order, with a synchronous nuke that discards every queued result.
module cdb_arbiter #(
   parameter int WAYS   = 2,
   parameter int NUM_FU = 4,
   parameter int QDEPTH = 2,
   parameter int ROB    = 32,
   parameter int PRF    = 64,
   parameter int XLEN   = 32
) (
   input  logic                                  clock,
   input  logic                                  reset,
   input  logic                                  nuke,
   input  logic [NUM_FU-1:0]                     fu_valid,
   input  logic [NUM_FU-1:0][$clog2(ROB)-1:0]    fu_rob_idx,
   input  logic [NUM_FU-1:0][$clog2(PRF)-1:0]    fu_dest_PRN,
   input  logic [NUM_FU-1:0]                     fu_reg_write,
   input  logic [NUM_FU-1:0][XLEN-1:0]           fu_value,
   input  logic [NUM_FU-1:0]                     fu_direction,
   input  logic [NUM_FU-1:0][XLEN-1:0]           fu_target,
   output logic [NUM_FU-1:0]                     fu_ready,
   output logic [WAYS-1:0]                       CDB_valid,
   output logic [WAYS-1:0][$clog2(ROB)-1:0]      CDB_ROB_idx,
   output logic [WAYS-1:0][$clog2(PRF)-1:0]      CDB_dest_PRN,
   output logic [WAYS-1:0]                       CDB_reg_write,
   output logic [WAYS-1:0][XLEN-1:0]             CDB_value,
   output logic [WAYS-1:0]                       CDB_direction,
   output logic [WAYS-1:0][XLEN-1:0]             CDB_target
);

   localparam int ROB_W = $clog2(ROB);
   localparam int PRN_W = $clog2(PRF);
   localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int CNT_W = $clog2(QDEPTH) + 1;
   localparam int RR_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(QDEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(QDEPTH);

   typedef struct packed {
      logic [ROB_W-1:0] rob_idx;
      logic [PRN_W-1:0] dest_prn;
      logic             reg_write;
      logic [XLEN-1:0]  value;
      logic             direction;
      logic [XLEN-1:0]  target;
   } entry_t;

   entry_t           r_mem   [NUM_FU][QDEPTH];
   logic [PTR_W-1:0] r_head  [NUM_FU];
   logic [PTR_W-1:0] r_tail  [NUM_FU];
   logic [CNT_W-1:0] r_count [NUM_FU];
   logic [RR_W-1:0]  r_rr_ptr;

   logic [NUM_FU-1:0] w_ready;
   logic [NUM_FU-1:0] w_nonempty;
   logic [NUM_FU-1:0] w_enq;
   logic [NUM_FU-1:0] w_grant;
   logic              w_any_grant;
   logic [RR_W-1:0]   w_rr_next;
   logic [WAYS-1:0]   w_lane_valid;
   logic [RR_W-1:0]   w_lane_fu    [WAYS];
   entry_t            w_fu_entry   [NUM_FU];
   entry_t            w_head_entry [NUM_FU];
   entry_t            w_lane_entry [WAYS];

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   // Readiness looks only at the registered count, so a full queue stays
   // closed in the cycle it drains; nuke does not gate it.
   always_comb begin
      for (int f = 0; f < NUM_FU; f++) begin
         w_ready[f]    = !reset && (r_count[f] < CNT_FULL);
         w_nonempty[f] = (r_count[f] != '0);
         w_enq[f]      = fu_valid[f] && w_ready[f] && !nuke;

         w_fu_entry[f].rob_idx   = fu_rob_idx[f];
         w_fu_entry[f].dest_prn  = fu_dest_PRN[f];
         w_fu_entry[f].reg_write = fu_reg_write[f];
         w_fu_entry[f].value     = fu_value[f];
         w_fu_entry[f].direction = fu_direction[f];
         w_fu_entry[f].target    = fu_target[f];

         w_head_entry[f] = r_mem[f][r_head[f]];
      end
   end

   assign fu_ready = w_ready;

   // Round-robin scan starting at r_rr_ptr; grants fill lanes in scan order.
   always_comb begin
      int n_grants;
      // NOTE: every output of a combinational block is defaulted up front so
      // that no path through the loops leaves a value held, which would infer a latch.
      n_grants     = 0;
      w_grant      = '0;
      w_lane_valid = '0;
      w_rr_next    = r_rr_ptr;
      for (int w = 0; w < WAYS; w++) begin
         w_lane_fu[w] = '0;
      end
      if (!reset && !nuke) begin
         for (int k = 0; k < NUM_FU; k++) begin
            for (int f = 0; f < NUM_FU; f++) begin
               if (f == (int'(r_rr_ptr) + k) % NUM_FU && w_nonempty[f] && n_grants < WAYS) begin
                  w_grant[f] = 1'b1;
                  for (int w = 0; w < WAYS; w++) begin
                     if (w == n_grants) begin
                        w_lane_valid[w] = 1'b1;
                        w_lane_fu[w]    = RR_W'(f);
                     end
                  end
                  n_grants  = n_grants + 1;
                  w_rr_next = RR_W'((f + 1) % NUM_FU);
               end
            end
         end
      end
   end

   assign w_any_grant = |w_grant;

   // Lane mux: an idle lane carries all-zero fields.
   always_comb begin
      for (int w = 0; w < WAYS; w++) begin
         w_lane_entry[w] = '0;
         for (int f = 0; f < NUM_FU; f++) begin
            if (w_lane_valid[w] && w_lane_fu[w] == RR_W'(f)) begin
               w_lane_entry[w] = w_head_entry[f];
            end
         end
      end
   end

   always_comb begin
      CDB_valid = w_lane_valid;
      for (int w = 0; w < WAYS; w++) begin
         CDB_ROB_idx[w]   = w_lane_entry[w].rob_idx;
         CDB_dest_PRN[w]  = w_lane_entry[w].dest_prn;
         CDB_reg_write[w] = w_lane_entry[w].reg_write;
         CDB_value[w]     = w_lane_entry[w].value;
         CDB_direction[w] = w_lane_entry[w].direction;
         CDB_target[w]    = w_lane_entry[w].target;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clock) begin
      if (reset || nuke) begin
         for (int f = 0; f < NUM_FU; f++) begin
            r_head[f]  <= '0;
            r_tail[f]  <= '0;
            r_count[f] <= '0;
         end
         r_rr_ptr <= '0;
      end else begin
         for (int f = 0; f < NUM_FU; f++) begin
            if (w_enq[f]) begin
               r_tail[f] <= ptr_inc(r_tail[f]);
            end
            if (w_grant[f]) begin
               r_head[f] <= ptr_inc(r_head[f]);
            end
            if (w_enq[f] && !w_grant[f]) begin
               r_count[f] <= r_count[f] + CNT_W'(1);
            end else if (!w_enq[f] && w_grant[f]) begin
               r_count[f] <= r_count[f] - CNT_W'(1);
            end
         end
         if (w_any_grant) begin
            r_rr_ptr <= w_rr_next;
         end
      end
   end

   // NOTE: the entry storage is deliberately not reset; the counts and
   // pointers alone decide which slots hold live data.
   always_ff @(posedge clock) begin
      for (int f = 0; f < NUM_FU; f++) begin
         if (w_enq[f]) begin
            r_mem[f][r_tail[f]] <= w_fu_entry[f];
         end
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: stimulus pushes hand-computed CDB results into
// a scoreboard queue that an independent negedge monitor drains and compares.
module tb_cdb_arbiter;

   localparam int WAYS   = 2;
   localparam int NUM_FU = 4;
   localparam int XLEN   = 32;

   logic                          clock;
   logic                          reset;
   logic                          nuke;
   logic [NUM_FU-1:0]             fu_valid;
   logic [NUM_FU-1:0][4:0]        fu_rob_idx;
   logic [NUM_FU-1:0][5:0]        fu_dest_PRN;
   logic [NUM_FU-1:0]             fu_reg_write;
   logic [NUM_FU-1:0][XLEN-1:0]   fu_value;
   logic [NUM_FU-1:0]             fu_direction;
   logic [NUM_FU-1:0][XLEN-1:0]   fu_target;
   logic [NUM_FU-1:0]             fu_ready;
   logic [WAYS-1:0]               CDB_valid;
   logic [WAYS-1:0][4:0]          CDB_ROB_idx;
   logic [WAYS-1:0][5:0]          CDB_dest_PRN;
   logic [WAYS-1:0]               CDB_reg_write;
   logic [WAYS-1:0][XLEN-1:0]     CDB_value;
   logic [WAYS-1:0]               CDB_direction;
   logic [WAYS-1:0][XLEN-1:0]     CDB_target;

   cdb_arbiter #(
      .WAYS(WAYS), .NUM_FU(NUM_FU), .QDEPTH(2), .ROB(32), .PRF(64), .XLEN(XLEN)
   ) dut (
      .clock(clock), .reset(reset), .nuke(nuke),
      .fu_valid(fu_valid), .fu_rob_idx(fu_rob_idx), .fu_dest_PRN(fu_dest_PRN),
      .fu_reg_write(fu_reg_write), .fu_value(fu_value), .fu_direction(fu_direction),
      .fu_target(fu_target), .fu_ready(fu_ready),
      .CDB_valid(CDB_valid), .CDB_ROB_idx(CDB_ROB_idx), .CDB_dest_PRN(CDB_dest_PRN),
      .CDB_reg_write(CDB_reg_write), .CDB_value(CDB_value), .CDB_direction(CDB_direction),
      .CDB_target(CDB_target)
   );

   typedef struct packed {
      logic [0:0]  lane;
      logic [4:0]  rob;
      logic [5:0]  prn;
      logic        rw;
      logic [31:0] value;
      logic        dir;
      logic [31:0] tgt;
   } cdb_t;

   cdb_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic cdb_t mk(input int lane, input logic [4:0] rob, input logic [5:0] prn,
                               input logic rw, input logic [31:0] value, input logic dir,
                               input logic [31:0] tgt);
      cdb_t c;
      c.lane = lane[0]; c.rob = rob; c.prn = prn; c.rw = rw;
      c.value = value; c.dir = dir; c.tgt = tgt;
      return c;
   endfunction

   // Canonical payload derived from the ROB index, used by the bulk tests.
   function automatic cdb_t std(input int lane, input logic [4:0] rob);
      return mk(lane, rob, {1'b1, rob}, ~rob[1], 32'hA000_0000 | {27'd0, rob},
                rob[0], {25'd0, rob, 2'b00});
   endfunction

   task automatic drive(input int fu, input cdb_t c);
      fu_valid[fu]     = 1'b1;
      fu_rob_idx[fu]   = c.rob;
      fu_dest_PRN[fu]  = c.prn;
      fu_reg_write[fu] = c.rw;
      fu_value[fu]     = c.value;
      fu_direction[fu] = c.dir;
      fu_target[fu]    = c.tgt;
   endtask

   task automatic push_std(input int fu, input logic [4:0] rob);
      drive(fu, std(0, rob));
   endtask

   task automatic expect_std(input int lane, input logic [4:0] rob);
      exp_q.push_back(std(lane, rob));
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      fu_valid = '0;
      nuke     = 1'b0;
   endtask

   task automatic mid();
      @(negedge clock);
   endtask

   // Monitor: every valid lane must match the next scoreboard entry; idle lanes must be all-zero.
   initial begin : monitor
      cdb_t got;
      forever begin
         @(negedge clock);
         for (int w = 0; w < WAYS; w++) begin
            got = mk(w, CDB_ROB_idx[w], CDB_dest_PRN[w], CDB_reg_write[w],
                     CDB_value[w], CDB_direction[w], CDB_target[w]);
            if (CDB_valid[w]) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL cdb_unexpected lane=%0d rob=%0d expected none at %0t",
                           w, got.rob, $time);
               end else begin
                  check("cdb_result", got, exp_q.pop_front());
               end
            end else begin
               check("cdb_idle_fields", {got.rob, got.prn, got.rw, got.value, got.dir, got.tgt}, '0);
            end
         end
      end
   end

   initial begin : stimulus
      reset        = 1'b1;
      nuke         = 1'b0;
      fu_valid     = '0;
      fu_rob_idx   = '0;
      fu_dest_PRN  = '0;
      fu_reg_write = '0;
      fu_value     = '0;
      fu_direction = '0;
      fu_target    = '0;

      // Reset held with every FU presenting a result: nothing may be accepted or shown.
      for (int f = 0; f < NUM_FU; f++) push_std(f, 5'(f + 1));
      mid();
      check("reset_ready", fu_ready, 4'b0000);
      check("reset_cdb_valid", CDB_valid, 2'b00);
      @(posedge clock);
      mid();
      check("reset_ready_2", fu_ready, 4'b0000);
      check("reset_cdb_valid_2", CDB_valid, 2'b00);
      tick();
      reset = 1'b0;
      mid();
      check("post_reset_ready", fu_ready, 4'b1111);
      check("post_reset_empty", CDB_valid, 2'b00);

      // Latency and lane packing.
      tick();
      drive(1, mk(0, 5'd5, 6'd9, 1'b1, 32'h0000_DEAD, 1'b0, 32'h0));
      drive(3, mk(0, 5'd7, 6'd0, 1'b0, 32'h0, 1'b1, 32'h0000_0100));
      exp_q.push_back(mk(0, 5'd5, 6'd9, 1'b1, 32'h0000_DEAD, 1'b0, 32'h0));
      exp_q.push_back(mk(1, 5'd7, 6'd0, 1'b0, 32'h0, 1'b1, 32'h0000_0100));
      mid();
      check("no_bypass", CDB_valid, 2'b00);
      tick();
      mid();
      check("pack_valid", CDB_valid, 2'b11);
      tick();
      mid();
      check("pack_drained", CDB_valid, 2'b00);

      // Round-robin: grants alternate {0,1},{2,3} while queues are kept topped up.
      for (int r = 10; r <= 21; r++) expect_std((r - 10) % 2, 5'(r));
      for (int f = 0; f < NUM_FU; f++) push_std(f, 5'(10 + f));
      tick();
      for (int f = 0; f < NUM_FU; f++) push_std(f, 5'(14 + f));
      tick();
      push_std(0, 5'd18);
      push_std(1, 5'd19);
      tick();
      push_std(2, 5'd20);
      push_std(3, 5'd21);
      mid();
      check("rr_full_ready", fu_ready, 4'b1100);
      tick();
      tick();
      tick();
      tick();
      mid();
      check("rr_drained", CDB_valid, 2'b00);
      check("rr_ready", fu_ready, 4'b1111);

      // Backpressure: FU0 fills while others win the lanes; its held third push waits.
      expect_std(0, 5'd1);
      expect_std(0, 5'd5);  expect_std(1, 5'd7);
      expect_std(0, 5'd9);  expect_std(1, 5'd2);
      expect_std(0, 5'd6);  expect_std(1, 5'd8);
      expect_std(0, 5'd10); expect_std(1, 5'd3);
      expect_std(0, 5'd4);
      tick();
      push_std(0, 5'd1);
      tick();
      push_std(0, 5'd2); push_std(1, 5'd5); push_std(2, 5'd7); push_std(3, 5'd9);
      tick();
      push_std(0, 5'd3); push_std(1, 5'd6); push_std(2, 5'd8); push_std(3, 5'd10);
      tick();
      push_std(0, 5'd4);
      mid();
      check("bp_ready_full", fu_ready, 4'b0110);
      tick();
      push_std(0, 5'd4);
      mid();
      check("bp_ready_reopen", fu_ready, 4'b1111);
      tick();
      tick();
      tick();
      mid();
      check("bp_drained", CDB_valid, 2'b00);

      // Wrap-around: FU2 streams with one entry in flight, enqueue and dequeue each cycle.
      expect_std(0, 5'd30); expect_std(0, 5'd31); expect_std(0, 5'd0); expect_std(0, 5'd1);
      tick();
      push_std(2, 5'd30);
      tick();
      push_std(2, 5'd31);
      mid();
      check("wrap_ready", fu_ready, 4'b1111);
      tick();
      push_std(2, 5'd0);
      tick();
      push_std(2, 5'd1);
      tick();
      tick();
      mid();
      check("wrap_drained", CDB_valid, 2'b00);

      // Nuke: five entries queued, nuke with an FU0 push in the same cycle.
      expect_std(0, 5'd14); expect_std(1, 5'd11);
      tick();
      for (int f = 0; f < NUM_FU; f++) push_std(f, 5'(11 + f));
      tick();
      push_std(0, 5'd15); push_std(1, 5'd16); push_std(2, 5'd17);
      tick();
      nuke = 1'b1;
      push_std(0, 5'd18);
      mid();
      check("nuke_cdb_valid", CDB_valid, 2'b00);
      check("nuke_ready_unaffected", fu_ready, 4'b1001);
      tick();
      push_std(0, 5'd21);
      push_std(1, 5'd22);
      expect_std(0, 5'd21); expect_std(1, 5'd22);
      mid();
      check("post_nuke_empty", CDB_valid, 2'b00);
      check("post_nuke_ready", fu_ready, 4'b1111);
      tick();
      mid();
      check("post_nuke_rr_zero", CDB_valid, 2'b11);
      tick();
      mid();
      check("final_idle", CDB_valid, 2'b00);
      check("scoreboard_empty", 128'(exp_q.size()), 128'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
Completion-side driver of the common data bus (CDB) that the reorder buffer, reservation stations and PRF consume. Each functional unit pushes finished results into a small per-FU queue. Every cycle the block grants up to WAYS queue heads in round-robin order and drives them onto the WAYS CDB lanes (ROB index, dest PRN, value, branch direction/target). A processor nuke flushes all queued results.

Parameters:
WAYS, 2, number of CDB lanes (superscalar width)
NUM_FU, 4, number of functional-unit completion ports
QDEPTH, 2, entries per FU queue (power of 2, >=1)
ROB, 32, ROB entries; ROB index width = $clog2(ROB)
PRF, 64, physical registers; PRN width = $clog2(PRF)
XLEN, 32, data/address width

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high reset
nuke  in  1  ROB mispredict flush; synchronous
fu_valid  in  [NUM_FU]  FU i presents a result
fu_rob_idx  in  [NUM_FU][$clog2(ROB)]  ROB slot of result
fu_dest_PRN  in  [NUM_FU][$clog2(PRF)]  destination physical register
fu_reg_write  in  [NUM_FU]  result writes PRF
fu_value  in  [NUM_FU][XLEN]  result data
fu_direction  in  [NUM_FU]  resolved branch taken
fu_target  in  [NUM_FU][XLEN]  resolved branch target
fu_ready  out  [NUM_FU]  queue i can accept this cycle
CDB_valid  out  [WAYS]  lane valid
CDB_ROB_idx  out  [WAYS][$clog2(ROB)]  ROB slot completed
CDB_dest_PRN  out  [WAYS][$clog2(PRF)]  PRN written
CDB_reg_write  out  [WAYS]  PRN write enable
CDB_value  out  [WAYS][XLEN]  data
CDB_direction  out  [WAYS]  branch direction
CDB_target  out  [WAYS][XLEN]  branch target

Behaviour:
- State: per-FU circular FIFO (head ptr, tail ptr, count 0..QDEPTH), round-robin pointer rr_ptr [$clog2(NUM_FU)].
- Reset (reset=1 at posedge): all counts/pointers 0, rr_ptr=0. While reset is high: fu_ready=0, CDB_valid=0, all CDB fields 0.
- fu_ready[i] = (count[i] < QDEPTH). Depends on registered count only; no same-cycle dequeue credit.
- Enqueue: fu_valid[i] && fu_ready[i] writes the entry at the tail on posedge. fu_valid while not ready is a protocol error; the entry is dropped and the FIFO is not corrupted.
- No bypass. An entry enqueued at edge N is eligible for the CDB in the cycle after edge N at the earliest.
- Arbitration (combinational): scan FUs in order rr_ptr, rr_ptr+1, ... mod NUM_FU. Each non-empty FIFO grants its head, at most one grant per FU per cycle, until WAYS grants are made.
- Grants pack into lanes 0,1,... in scan order. Unused lanes: CDB_valid=0 and all fields 0.
- CDB outputs are combinational from FIFO heads. Consumers sample at the next posedge; granted heads dequeue on that posedge.
- rr_ptr update: (index of last granted FU + 1) mod NUM_FU. Unchanged if no grant.
- Simultaneous enqueue and dequeue on the same FIFO: count unchanged, both pointers advance (wrap mod QDEPTH).
- nuke=1: CDB_valid forced 0 that cycle. On posedge all FIFOs empty, rr_ptr=0, and same-cycle enqueues are discarded. fu_ready is unaffected in the nuke cycle.
- reset has priority over nuke; both give the same end state.
- Count width $clog2(QDEPTH)+1 so that count=QDEPTH is representable.

Test Plan:
- Reset: hold reset 2 cycles with fu_valid=4'b1111 -> fu_ready=0, CDB_valid=0. After release, all queues empty and fu_ready=4'b1111.
- Latency/lane packing: one cycle FU1 {rob 5, PRN 9, value 0xDEAD} and FU3 {rob 7, direction 1, target 0x100} -> next cycle lane0=rob5, lane1=rob7/target 0x100, CDB_valid=2'b11. Following cycle CDB_valid=0.
- Round-robin fairness: all four FUs keep queues full (QDEPTH=2) from rr_ptr=0 -> grants {0,1}, {2,3}, {0,1}, {2,3} on consecutive cycles. No FU starves.
- Backpressure/full: FU0 pushes 3 consecutive cycles while other FUs push every cycle -> fu_ready[0] drops to 0 after 2 unserved pushes. The third push is only accepted when count<2. No FIFO corruption; rob indices emerge in enqueue order.
- Wrap-around: FU2 streams rob idx 30, 31, 0, 1 (simultaneous enq/deq) -> CDB shows 30, 31, 0, 1 in order with the FIFO pointers wrapping.
- Nuke: queues hold 5 entries, assert nuke with FU0 valid -> that cycle CDB_valid=0. Next cycle all queues empty, rr_ptr=0, CDB_valid=0, and the FU0 entry is not seen.
